// File: rtl/mem_access_if.sv
// Bundle of the core-side request/response handshake and the RAM-side
// address/control bus used by mem_access_unit. The bidirectional RAM data
// lines stay a plain port on the unit so tristate resolution is kept simple.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [1:0]  mem_size;

  // Core / environment side: issues requests, consumes responses, observes the bus
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_rw, mem_size
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_rw, mem_size
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end between the execute stage and the on-chip RAM bus.
// One request at a time: decode width and legality, run a single bus cycle
// (one cycle for stores, two for the registered RAM read), then hold a single
// response until the core takes it. Every output comes from registers or from
// the registered state, never combinationally from the request inputs.
module mem_access_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  mem_access_if.slave bus,
  inout  wire  [31:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ISSUE,
    READ_DATA,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        dataOe_q;

  logic [1:0]  reqSize;
  logic        reqIllegal;
  logic        reqMisaligned;
  logic        reqBad;
  logic        handshake;
  logic        busActive;
  logic [31:0] loadExt;

  // Decode width, legality and alignment of the request currently offered
  always_comb begin
    reqSize       = 2'b00;
    reqIllegal    = 1'b0;
    reqMisaligned = 1'b0;
    case (bus.req_funct3)
      3'b000:         reqSize = 2'b01;
      3'b001:         reqSize = 2'b10;
      3'b010:         reqSize = 2'b11;
      3'b100, 3'b101: begin
        reqSize    = bus.req_funct3[0] ? 2'b10 : 2'b01;
        reqIllegal = bus.req_we;
      end
      default:        reqIllegal = 1'b1;
    endcase
    if (CHECK_ALIGN) begin
      reqMisaligned = ((reqSize == 2'b10) && bus.req_addr[0]) ||
                      ((reqSize == 2'b11) && (bus.req_addr[1:0] != 2'b00));
    end
  end

  assign reqBad    = reqIllegal || reqMisaligned;
  assign handshake = (state_q == IDLE) && bus.req_valid;

  // State register; the data driver enable is registered alongside it so the
  // unit only drives the shared data lines during WRITE and reset drops it at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dataOe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dataOe_q <= (state_d == WRITE);
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (reqBad)          state_d = RESP;
          else if (bus.req_we) state_d = WRITE;
          else                 state_d = READ_ISSUE;
        end
      end
      WRITE:      state_d = RESP;
      READ_ISSUE: state_d = READ_DATA;
      READ_DATA:  state_d = RESP;
      RESP:       if (bus.resp_ready) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state and captured request
  always_comb begin
    busActive      = (state_q == WRITE) || (state_q == READ_ISSUE) || (state_q == READ_DATA);
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    bus.mem_addr   = busActive ? addr_q : 32'h0;
    bus.mem_rw     = (state_q == WRITE);
    bus.mem_size   = busActive ? size_q : 2'b00;
  end

  assign mem_data = dataOe_q ? wdata_q : 32'bz;

  // Zero- or sign-extend the RAM read data according to the captured width
  always_comb begin
    case (funct3_q)
      3'b000:  loadExt = {{24{mem_data[7]}}, mem_data[7:0]};
      3'b001:  loadExt = {{16{mem_data[15]}}, mem_data[15:0]};
      3'b100:  loadExt = {24'h0, mem_data[7:0]};
      3'b101:  loadExt = {16'h0, mem_data[15:0]};
      default: loadExt = mem_data;
    endcase
  end

  // Request capture on the handshake and load data capture at the end of READ_DATA
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      size_q   <= 2'b00;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else if (handshake) begin
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      funct3_q <= bus.req_funct3;
      size_q   <= reqSize;
      rdata_q  <= 32'h0;
      err_q    <= reqBad;
    end else if (state_q == READ_DATA) begin
      rdata_q  <= loadExt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-addressed RAM with a registered read
// buffer sits on the bus, a transaction-level reference model predicts every
// output cycle by cycle, and directed tests pin known values by hand.
module tb_mem_access_unit;

  localparam bit CHECK_ALIGN = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire [31:0] memData;

  mem_access_if busIf ();

  mem_access_unit #(.CHECK_ALIGN(CHECK_ALIGN)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (busIf.slave),
    .mem_data (memData)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rwCycles = 0;

  logic [7:0]  ramBytes [0:255];
  logic [7:0]  refMem   [0:255];
  logic [31:0] ramBuf = 32'h0;
  logic [2:0]  legalLoads [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  // Reference model state: one outstanding transaction, counted in cycles since handshake
  bit          mBusy  = 1'b0;
  int          mCycle = 0;
  int          mLat   = 0;
  bit          mWe    = 1'b0;
  bit          mErr   = 1'b0;
  int          mBytes = 0;
  logic [31:0] mAddr  = 32'h0;
  logic [31:0] mWdata = 32'h0;
  logic [31:0] mRdata = 32'h0;
  logic [1:0]  mSize  = 2'b00;

  wire expResp = mBusy && (mCycle >= mLat);
  wire expBus  = mBusy && !expResp;

  function automatic int widthBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int sizeBytes(input logic [1:0] sizeCode);
    return (sizeCode == 2'd1) ? 1 : (sizeCode == 2'd2) ? 2 : (sizeCode == 2'd3) ? 4 : 0;
  endfunction

  function automatic logic [1:0] sizeCodeOf(input int n);
    return (n == 1) ? 2'd1 : (n == 2) ? 2'd2 : 2'd3;
  endfunction

  function automatic bit requestBad(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    bit misaligned;
    legal      = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misaligned = CHECK_ALIGN && ((addr % 32'(widthBytes(f3))) != 32'd0);
    return !legal || misaligned;
  endfunction

  function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = widthBytes(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[8'(addr + 32'(i))];
    if (!f3[2] && n < 4 && v[8*n-1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM: writes at the edge ending a write cycle, read buffer latched from the bus
  always @(posedge clk) begin
    if (busIf.mem_size != 2'b00) begin
      if (busIf.mem_rw) begin
        for (int i = 0; i < 4; i++) begin
          if (i < sizeBytes(busIf.mem_size))
            ramBytes[8'(busIf.mem_addr + 32'(i))] <= memData[8*i +: 8];
        end
      end else begin
        ramBuf <= {ramBytes[8'(busIf.mem_addr + 32'd3)], ramBytes[8'(busIf.mem_addr + 32'd2)],
                   ramBytes[8'(busIf.mem_addr + 32'd1)], ramBytes[8'(busIf.mem_addr)]};
      end
    end
  end

  assign memData = (!busIf.mem_rw && busIf.mem_size != 2'b00) ? ramBuf : 32'bz;

  // Count cycles in which the bus performs a write
  always @(negedge clk) begin
    if (!rst && busIf.mem_rw) rwCycles <= rwCycles + 1;
  end

  // Reference model: latency, error and data of each request from the rules directly
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy  <= 1'b0;
      mCycle <= 0;
    end else if (!mBusy) begin
      if (busIf.req_valid) begin
        mBusy  <= 1'b1;
        mCycle <= 1;
        mWe    <= busIf.req_we;
        mAddr  <= busIf.req_addr;
        mWdata <= busIf.req_wdata;
        mBytes <= widthBytes(busIf.req_funct3);
        mSize  <= sizeCodeOf(widthBytes(busIf.req_funct3));
        mErr   <= requestBad(busIf.req_we, busIf.req_funct3, busIf.req_addr);
        mLat   <= requestBad(busIf.req_we, busIf.req_funct3, busIf.req_addr) ? 1 :
                  (busIf.req_we ? 2 : 3);
        mRdata <= (requestBad(busIf.req_we, busIf.req_funct3, busIf.req_addr) || busIf.req_we) ?
                  32'h0 : loadValue(busIf.req_funct3, busIf.req_addr);
      end
    end else if (mCycle >= mLat) begin
      if (busIf.resp_ready) mBusy <= 1'b0;
    end else begin
      if (mWe && mCycle == 1) begin
        for (int i = 0; i < 4; i++) begin
          if (i < mBytes) refMem[8'(mAddr + 32'(i))] <= mWdata[8*i +: 8];
        end
      end
      mCycle <= mCycle + 1;
    end
  end

  // Every cycle out of reset: compare all outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("req_ready",  32'(busIf.req_ready),  32'(!mBusy));
      checkOutput("resp_valid", 32'(busIf.resp_valid), 32'(expResp));
      checkOutput("mem_addr",   busIf.mem_addr,        expBus ? mAddr : 32'h0);
      checkOutput("mem_rw",     32'(busIf.mem_rw),     32'(expBus && mWe));
      checkOutput("mem_size",   32'(busIf.mem_size),   32'(expBus ? mSize : 2'b00));
      if (expResp) begin
        checkOutput("resp_rdata", busIf.resp_rdata,     mRdata);
        checkOutput("resp_err",   32'(busIf.resp_err),  32'(mErr));
      end
    end
  end

  // One request, one response; during the hold a spurious request is offered
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold,
                               output int lat, output logic [31:0] rdata, output logic err);
    int guard;
    @(negedge clk);
    busIf.req_valid  = 1'b1;
    busIf.req_we     = we;
    busIf.req_funct3 = f3;
    busIf.req_addr   = addr;
    busIf.req_wdata  = wdata;
    busIf.resp_ready = 1'b0;
    guard = 0;
    while (!busIf.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("readyForRequest", 32'(busIf.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    busIf.req_valid = 1'b0;
    lat = 1;
    while (!busIf.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("respArrives", 32'(busIf.resp_valid), 32'd1);
    rdata = busIf.resp_rdata;
    err   = busIf.resp_err;
    for (int i = 0; i < hold; i++) begin
      busIf.req_valid  = 1'b1;
      busIf.req_we     = 1'b1;
      busIf.req_funct3 = 3'b010;
      busIf.req_addr   = 32'h40 + 32'(4 * i);
      busIf.req_wdata  = $urandom;
      @(negedge clk);
    end
    busIf.req_valid  = 1'b0;
    busIf.resp_ready = 1'b1;
    @(negedge clk);
    busIf.resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          rw0;

    for (int i = 0; i < 256; i++) begin
      ramBytes[i] = 8'(i * 37 + 5);
      refMem[i]   = 8'(i * 37 + 5);
    end
    busIf.req_valid  = 1'b0;
    busIf.req_we     = 1'b0;
    busIf.req_funct3 = 3'b000;
    busIf.req_addr   = 32'h0;
    busIf.req_wdata  = 32'h0;
    busIf.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rstReqReady",  32'(busIf.req_ready),  32'd1);
    checkOutput("rstRespValid", 32'(busIf.resp_valid), 32'd0);
    checkOutput("rstRdata",     busIf.resp_rdata,      32'h0);
    checkOutput("rstErr",       32'(busIf.resp_err),   32'd0);
    checkOutput("rstAddr",      busIf.mem_addr,        32'h0);
    checkOutput("rstRw",        32'(busIf.mem_rw),     32'd0);
    checkOutput("rstSize",      32'(busIf.mem_size),   32'd0);
    rst = 1'b0;

    // Word store then word load
    rw0 = rwCycles;
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, lat, rd, er);
    checkOutput("swLatency", 32'(lat), 32'd2);
    checkOutput("swErr",     32'(er),  32'd0);
    checkOutput("swRdata",   rd,       32'h0);
    checkOutput("swRwCycles", 32'(rwCycles - rw0), 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, lat, rd, er);
    checkOutput("lwLatency", 32'(lat), 32'd3);
    checkOutput("lwRdata",   rd,       32'hDEADBEEF);

    // Byte store, signed and unsigned byte loads
    applyStimulus(1'b1, 3'b000, 32'h20, 32'hCAFE0080, 0, lat, rd, er);
    applyStimulus(1'b0, 3'b000, 32'h20, 32'h0, 0, lat, rd, er);
    checkOutput("lbRdata",  rd, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h20, 32'h0, 0, lat, rd, er);
    checkOutput("lbuRdata", rd, 32'h00000080);

    // Halfword store, signed and unsigned halfword loads
    applyStimulus(1'b1, 3'b001, 32'h22, 32'h55558001, 0, lat, rd, er);
    applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 0, lat, rd, er);
    checkOutput("lhRdata",  rd, 32'hFFFF8001);
    applyStimulus(1'b0, 3'b101, 32'h22, 32'h0, 0, lat, rd, er);
    checkOutput("lhuRdata", rd, 32'h00008001);

    // Misaligned and illegal requests
    applyStimulus(1'b0, 3'b010, 32'h13, 32'h0, 0, lat, rd, er);
    checkOutput("lwMisErr", 32'(er), 32'd1);
    checkOutput("lwMisLat", 32'(lat), 32'd1);
    checkOutput("lwMisRdata", rd, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h21, 32'h0, 0, lat, rd, er);
    checkOutput("lhMisErr", 32'(er), 32'd1);
    applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, 0, lat, rd, er);
    checkOutput("ldIllegalErr", 32'(er), 32'd1);
    applyStimulus(1'b1, 3'b100, 32'h20, 32'h11223344, 0, lat, rd, er);
    checkOutput("sbuIllegalErr", 32'(er), 32'd1);

    // Response held for five cycles while another request is offered
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 5, lat, rd, er);
    checkOutput("holdRdata", rd, 32'hDEADBEEF);

    // Reset in the middle of a write cycle suppresses the write
    @(negedge clk);
    busIf.req_valid  = 1'b1;
    busIf.req_we     = 1'b1;
    busIf.req_funct3 = 3'b010;
    busIf.req_addr   = 32'h30;
    busIf.req_wdata  = 32'h12345678;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    busIf.req_valid = 1'b0;
    checkOutput("midRstReqReady",  32'(busIf.req_ready),  32'd1);
    checkOutput("midRstRespValid", 32'(busIf.resp_valid), 32'd0);
    checkOutput("midRstAddr",      busIf.mem_addr,        32'h0);
    checkOutput("midRstRw",        32'(busIf.mem_rw),     32'd0);
    checkOutput("midRstSize",      32'(busIf.mem_size),   32'd0);
    checkOutput("midRstDataDriven", 32'(memData === 32'h12345678), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, 0, lat, rd, er);
    checkOutput("afterRstRdata", rd, 32'h643F1AF5);

    // Randomized traffic checked by the model every cycle
    for (int t = 0; t < 200; t++) begin
      bit          we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) != 0)
        f3 = we ? 3'($urandom_range(0, 2)) : legalLoads[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(widthBytes(f3)) - 32'd1);
      applyStimulus(we, f3, a, $urandom, int'($urandom_range(0, 2)), lat, rd, er);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end between the RV32 core's execute stage and the on-chip RAM bus. Accepts one memory request at a time through a valid/ready handshake, checks alignment and decodes the RV32 funct3 width, then drives the RAM's address/data/rw/size bus. For loads it waits out the RAM's registered read, then zero- or sign-extends the captured value. Each request gets exactly one response, held until the core accepts it.

## Interface
- CHECK_ALIGN, 1: when 1, misaligned halfword/word accesses are rejected with an error; when 0, they pass to the bus unchecked.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal funct3.
- mem_addr  out  32  RAM address.
- mem_data  inout  32  RAM data. Driven with store data only while mem_rw=1; high-Z otherwise.
- mem_rw  out  1  1 = write, 0 = read.
- mem_size  out  2  00 idle, 01 byte, 10 half, 11 word.

## Operation
- FSM states: IDLE, WRITE, READ_ISSUE, READ_DATA, RESP.
- Request capture:
  - IDLE with req_valid=1 is a handshake. On that edge, register addr, wdata, we and funct3, and decode the size.
  - Illegal encodings are funct3 ∉ {000, 001, 010, 100, 101} for loads and funct3 ∉ {000, 001, 010} for stores.
  - Misaligned (CHECK_ALIGN=1) means a half with addr[0]=1, or a word with addr[1:0]≠00.
- IDLE transitions:
  - Illegal or misaligned → RESP with resp_err=1 and resp_rdata=0. No bus cycle is issued.
  - Store → WRITE.
  - Load → READ_ISSUE.
- WRITE: drive mem_addr, mem_rw=1, mem_size and mem_data=wdata (low bytes carry the data; upper bytes are don't-care but driven). Next state: RESP with err=0 and rdata=0.
- READ_ISSUE: drive mem_addr, mem_rw=0 and mem_size. The RAM latches its read buffer at the end of this cycle. Next state: READ_DATA.
- READ_DATA: hold the same bus values. On the edge, capture mem_data and extend it:
  - LB: sign from bit 7.
  - LBU: zero from bit 7 up.
  - LH: sign from bit 15.
  - LHU: zero from bit 15 up.
  - LW: unchanged.
  - Next state: RESP.
- RESP: resp_valid=1, outputs stable. When resp_ready=1 on an edge → IDLE. A new request is accepted no earlier than the following cycle (no IDLE bypass).
- Bus outputs in IDLE and RESP: mem_size=00, mem_rw=0, mem_addr=0, mem_data high-Z.
- Reset, asynchronous, at any time:
  - State → IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_addr=0, mem_rw=0, mem_size=00, mem_data high-Z.
  - A reset asserted during WRITE before the clock edge suppresses the write.
- Bus driver: mem_data output enable is a registered function of state (WRITE only). This prevents contention with the RAM's read driver, which is active only when rw=0 and size≠00.

## Timing
- Cycle 0 is the handshake edge.
- Store: bus active cycle 1, RAM written at edge 1, resp_valid from cycle 2. Minimum request-to-request spacing is 3 cycles.
- Load: bus active cycles 1–2, data captured at edge 2, resp_valid from cycle 3. Minimum spacing is 4 cycles.
- Error: resp_valid from cycle 1.
- All outputs are registered or decoded only from the registered state/request; no combinational path from req_* or resp_ready to any output.
- req_ready=0 in every state except IDLE. req_valid in other states is ignored, not queued.
- resp_valid stays high, with rdata/err stable, for any number of cycles until resp_ready=1.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → store response err=0 at cycle 2; load resp_rdata=0xDEADBEEF at cycle 3; bus shows size=11, rw=1 for exactly one cycle.
- SB 0x20 data 0x80, then LB 0x20 → rdata 0xFFFFFF80; LBU 0x20 → 0x00000080.
- SH 0x22 data 0x8001, then LH → 0xFFFF8001 and LHU → 0x00008001.
- LW 0x13 and LH 0x21 with CHECK_ALIGN=1, plus load funct3=011 → err=1, rdata=0 at cycle 1, mem_size stays 00 throughout.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and rdata stable, req_ready=0, a new req_valid is ignored; resp_ready=1 → IDLE next edge.
- Assert rst during WRITE, before the edge, of SW 0x30 data 0x12345678 → outputs at reset values immediately, mem_data high-Z. A later LW 0x30 returns the prior contents, not 0x12345678.
